// File: rtl/pico_clk_pkg.sv
// Shared definitions for the pico clock/step controller.
//   state_t                 : controller FSM state encoding (3-bit binary)
//   DEBOUNCE_CYCLES_DEFAULT : 10 ms of stable button at a 20 MHz system clock
package pico_clk_pkg;

    typedef enum logic [2:0] {
        S_STOP     = 3'd0,
        S_RUN      = 3'd1,
        S_STEP     = 3'd2,
        S_WAIT_REL = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 200000;

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces the front-panel step pushbutton.
//   clk, rst_n : system clock, async active-low reset
//   btn_async  : raw bouncy button, asynchronous to clk
//   level      : debounced button level (registered)
//   press      : one-cycle pulse, high in the cycle the debounced level rises
// The raw level must differ from the debounced level for DEBOUNCE_CYCLES
// consecutive cycles before it is accepted; any agreement restarts the count.
module button_debounce
    import pico_clk_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_async,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   btn_s;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_async};
        btn_s   = sync_q[SYNC_STAGES-1];
        cnt_d   = '0;
        level_d = level_q;
        press   = 1'b0;
        if (btn_s != level_q) begin
            // Accept on the last count value so the counter never wraps.
            if (cnt_q == CNT_MAX) begin
                level_d = btn_s;
                press   = btn_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/clock_step_ctrl.sv
// Run/step clock-enable controller for the pico core.
//   CLK, RST_N : 20 MHz system clock, async active-low reset
//   SLOW_CLK   : divided clock from the T-FF chain (asynchronous)
//   MODE       : panel switch, 1 = run, 0 = step (asynchronous)
//   STEP_BTN   : bouncy step pushbutton, active-high (asynchronous)
//   HALT       : synchronous halt level from the core
//   CPU_EN     : registered one-cycle enable to the core
//   RUNNING    : registered, high while in S_RUN
//   HALTED     : registered, high while in S_HALT
// Outputs are registered from the next-state value so they line up with
// state_q. Handshake: CPU_EN is a bare single-cycle strobe, no back-pressure.
module clock_step_ctrl
    import pico_clk_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SLOW_CLK,
    input  logic MODE,
    input  logic STEP_BTN,
    input  logic HALT,
    output logic CPU_EN,
    output logic RUNNING,
    output logic HALTED
);

    logic [SYNC_STAGES-1:0] slow_sync_q, slow_sync_d;
    logic [SYNC_STAGES-1:0] mode_sync_q, mode_sync_d;
    logic                   slow_prev_q, slow_prev_d;
    state_t                 state_q, state_d;
    logic                   cpu_en_q, cpu_en_d;
    logic                   running_q, running_d;
    logic                   halted_q, halted_d;

    logic slow_tick;
    logic mode_s;
    logic btn_level;
    logic press;

    button_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (CLK),
        .rst_n    (RST_N),
        .btn_async(STEP_BTN),
        .level    (btn_level),
        .press    (press)
    );

    always_comb begin
        slow_sync_d = {slow_sync_q[SYNC_STAGES-2:0], SLOW_CLK};
        mode_sync_d = {mode_sync_q[SYNC_STAGES-2:0], MODE};
        slow_prev_d = slow_sync_q[SYNC_STAGES-1];
        mode_s      = mode_sync_q[SYNC_STAGES-1];
        slow_tick   = slow_sync_q[SYNC_STAGES-1] & ~slow_prev_q;
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            S_STOP: begin
                // HALT wins; run mode swallows a coincident press.
                if (HALT) begin
                    state_d = S_HALT;
                end else if (mode_s) begin
                    state_d = S_RUN;
                end else if (press) begin
                    state_d  = S_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            S_RUN: begin
                if (HALT) begin
                    state_d = S_HALT;
                end else begin
                    cpu_en_d = slow_tick;
                    if (!mode_s) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STEP: begin
                // The step enable is already out; MODE cannot abort it.
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!btn_level) begin
                    state_d = S_STOP;
                end
            end
            S_HALT: begin
                if (!HALT) begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_STOP;
            end
        endcase
        running_d = (state_d == S_RUN);
        halted_d  = (state_d == S_HALT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slow_sync_q <= '0;
            mode_sync_q <= '0;
            slow_prev_q <= 1'b0;
            state_q     <= S_STOP;
            cpu_en_q    <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            slow_sync_q <= slow_sync_d;
            mode_sync_q <= mode_sync_d;
            slow_prev_q <= slow_prev_d;
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

    assign CPU_EN  = cpu_en_q;
    assign RUNNING = running_q;
    assign HALTED  = halted_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
module tb_clock_step_ctrl;
    import pico_clk_pkg::*;

    logic CLK;
    logic RST_N;
    logic SLOW_CLK;
    logic MODE;
    logic STEP_BTN;
    logic HALT;
    logic CPU_EN;
    logic RUNNING;
    logic HALTED;

    int checks;
    int errors;
    int cyc;
    int phase;
    int last_rise;
    bit slow_on;

    clock_step_ctrl #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SLOW_CLK(SLOW_CLK),
        .MODE    (MODE),
        .STEP_BTN(STEP_BTN),
        .HALT    (HALT),
        .CPU_EN  (CPU_EN),
        .RUNNING (RUNNING),
        .HALTED  (HALTED)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- driver ----------------
    // Advance one CLK edge, then move 1 time unit past it; outputs are
    // sampled and inputs driven at that point. Optionally generates a
    // 40-cycle SLOW_CLK (20 low, 20 high).
    task automatic step_clk();
        logic nv;
        @(posedge CLK);
        #1;
        cyc++;
        if (slow_on) begin
            nv = (phase >= 20);
            if (nv && !SLOW_CLK) last_rise = cyc;
            SLOW_CLK = nv;
            phase = (phase + 1) % 40;
        end
    endtask

    task automatic test_reset();
        bit got;
        RST_N = 1'b0;
        for (int i = 0; i < 10; i++) begin
            MODE     = i[0];
            STEP_BTN = i[1];
            SLOW_CLK = i[0] ^ i[1];
            HALT     = i[2];
            step_clk();
            checks++;
            if (CPU_EN !== 1'b0 || RUNNING !== 1'b0 || HALTED !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d: got en=%b run=%b halt=%b, want 0/0/0",
                         i, CPU_EN, RUNNING, HALTED);
            end
        end
        MODE = 1'b0; STEP_BTN = 1'b0; SLOW_CLK = 1'b0; HALT = 1'b0;
        step_clk();
        RST_N = 1'b1;
        MODE  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step_clk();
            if (RUNNING === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL reset_release_run: RUNNING=%b after 4 cycles, want 1", RUNNING);
        end
    endtask

    task automatic test_free_run();
        int pulses;
        bit prev_en;
        pulses = 0; prev_en = 1'b0;
        phase = 0; slow_on = 1'b1; last_rise = -100;
        for (int i = 0; i < 400; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) begin
                pulses++;
                checks++;
                if (prev_en || (cyc - last_rise) < 3 || (cyc - last_rise) > 5) begin
                    errors++;
                    $display("FAIL free_run_pulse: latency=%0d prev_en=%b, want 3..5 and 0",
                             cyc - last_rise, prev_en);
                end
            end
            prev_en = CPU_EN;
        end
        slow_on = 1'b0;
        SLOW_CLK = 1'b0;
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL free_run_count: got %0d pulses, want 10", pulses);
        end
    endtask

    task automatic test_step_bounce();
        int pulses;
        pulses = 0;
        MODE = 1'b0;
        for (int i = 0; i < 6; i++) step_clk();
        checks++;
        if (RUNNING !== 1'b0 || dut.state_q !== S_STOP) begin
            errors++;
            $display("FAIL step_enter_stop: RUNNING=%b state=%0d, want 0/%0d",
                     RUNNING, dut.state_q, S_STOP);
        end
        STEP_BTN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) STEP_BTN = ~STEP_BTN;
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL step_bounce_press: got %0d pulses during bounce, want 0", pulses);
        end
        STEP_BTN = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        checks++;
        if (dut.state_q !== S_WAIT_REL) begin
            errors++;
            $display("FAIL step_held_state: state=%0d, want %0d", dut.state_q, S_WAIT_REL);
        end
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) STEP_BTN = ~STEP_BTN;
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        STEP_BTN = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL step_pulse_count: got %0d pulses, want 1", pulses);
        end
        checks++;
        if (dut.state_q !== S_STOP || RUNNING !== 1'b0 || HALTED !== 1'b0) begin
            errors++;
            $display("FAIL step_return_stop: state=%0d run=%b halt=%b, want %0d/0/0",
                     dut.state_q, RUNNING, HALTED, S_STOP);
        end
    endtask

    task automatic test_halt();
        int pulses;
        bit got;
        pulses = 0;
        SLOW_CLK = 1'b0;
        MODE = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            step_clk();
            if (RUNNING === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL halt_enter_run: RUNNING=%b, want 1", RUNNING);
        end
        step_clk();
        // Rise here; the detected tick is live between the 2nd and 3rd edge.
        SLOW_CLK = 1'b1;
        step_clk();
        step_clk();
        HALT = 1'b1;
        step_clk();
        checks++;
        if (CPU_EN !== 1'b0 || HALTED !== 1'b1 || RUNNING !== 1'b0) begin
            errors++;
            $display("FAIL halt_beats_tick: en=%b halted=%b run=%b, want 0/1/0",
                     CPU_EN, HALTED, RUNNING);
        end
        MODE = 1'b0;
        SLOW_CLK = 1'b0;
        STEP_BTN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        STEP_BTN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || HALTED !== 1'b1) begin
            errors++;
            $display("FAIL halt_ignores_step: pulses=%0d halted=%b, want 0/1", pulses, HALTED);
        end
        HALT = 1'b0;
        step_clk();
        checks++;
        if (HALTED !== 1'b0 || dut.state_q !== S_STOP) begin
            errors++;
            $display("FAIL halt_release: halted=%b state=%0d, want 0/%0d",
                     HALTED, dut.state_q, S_STOP);
        end
    endtask

    task automatic test_mode_mid_step();
        int pulses;
        bit got;
        bit saw_stop;
        pulses = 0;
        got = 1'b0;
        MODE = 1'b0;
        STEP_BTN = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) begin
                got = 1'b1;
                pulses++;
            end
        end
        checks++;
        if (!got || dut.state_q !== S_STEP) begin
            errors++;
            $display("FAIL mid_step_pulse: got=%b state=%0d, want 1/%0d",
                     got, dut.state_q, S_STEP);
        end
        MODE = 1'b1;
        step_clk();
        checks++;
        if (CPU_EN !== 1'b0 || dut.state_q !== S_WAIT_REL) begin
            errors++;
            $display("FAIL mid_step_wait: en=%b state=%0d, want 0/%0d",
                     CPU_EN, dut.state_q, S_WAIT_REL);
        end
        for (int i = 0; i < 10; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        checks++;
        if (dut.state_q !== S_WAIT_REL || RUNNING !== 1'b0) begin
            errors++;
            $display("FAIL mid_step_hold: state=%0d run=%b, want %0d/0",
                     dut.state_q, RUNNING, S_WAIT_REL);
        end
        STEP_BTN = 1'b0;
        got = 1'b0;
        saw_stop = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
            if (dut.state_q === S_STOP) saw_stop = 1'b1;
            if (RUNNING === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || !saw_stop || pulses != 1) begin
            errors++;
            $display("FAIL mid_step_to_run: run=%b via_stop=%b pulses=%0d, want 1/1/1",
                     got, saw_stop, pulses);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        bit got;
        pulses = 0;
        got = 1'b0;
        SLOW_CLK = 1'b0;
        for (int i = 0; i < 4; i++) step_clk();
        SLOW_CLK = 1'b1;
        for (int i = 0; i < 6 && !got; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL arst_pulse_seen: no CPU_EN within 6 cycles, want 1");
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (CPU_EN !== 1'b0 || RUNNING !== 1'b0) begin
            errors++;
            $display("FAIL arst_truncate: en=%b run=%b, want 0/0", CPU_EN, RUNNING);
        end
        step_clk();
        RST_N = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step_clk();
            if (CPU_EN === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || RUNNING !== 1'b1) begin
            errors++;
            $display("FAIL arst_no_spurious: pulses=%0d run=%b, want 0/1", pulses, RUNNING);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0; errors = 0; cyc = 0; phase = 0; last_rise = -100; slow_on = 1'b0;
        RST_N = 1'b0; SLOW_CLK = 1'b0; MODE = 1'b0; STEP_BTN = 1'b0; HALT = 1'b0;
        test_reset();
        test_free_run();
        test_step_bounce();
        test_halt();
        test_mode_mid_step();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
